// File: rtl/subleq_core_pkg.sv
// Shared word size, main-FSM states and memory-access sub-phases for the SUBLEQ core.
// Also holds the branch-condition helper used at retire.
package subleq_core_pkg;

    localparam int WORD_SIZE       = 8;
    localparam int CORE_STATE_BITS = 3;
    localparam int ACC_PHASE_BITS  = 2;

    typedef logic [WORD_SIZE-1:0] word_t;

    typedef enum logic [CORE_STATE_BITS-1:0] {
        CORE_IDLE    = 3'd0,
        CORE_FETCH_A = 3'd1,
        CORE_FETCH_B = 3'd2,
        CORE_FETCH_C = 3'd3,
        CORE_READ_A  = 3'd4,
        CORE_READ_B  = 3'd5,
        CORE_WRITE_B = 3'd6,
        CORE_RETIRE  = 3'd7
    } core_state_e;

    typedef enum logic [ACC_PHASE_BITS-1:0] {
        ACC_ISSUE    = 2'd0,
        ACC_WAIT_ACK = 2'd1,
        ACC_WAIT_REL = 2'd2
    } acc_phase_e;

    // Signed "less than or equal to zero" on a two's-complement word.
    function automatic logic is_leq(input word_t d);
        return (d == '0) || d[WORD_SIZE-1];
    endfunction

endpackage

// File: rtl/subleq_mem_port.sv
// Four-phase req/ack master for one memory access at a time.
// Drives registered qualifiers to memory, captures load data, and pulses done on release.
module subleq_mem_port
    import subleq_core_pkg::*;
(
    input  logic  clk,
    input  logic  areset,
    input  logic  start,
    input  logic  is_store,
    input  word_t addr,
    input  word_t wdata,
    output logic  done,
    output word_t rdata,
    output logic  mem_req,
    output logic  mem_load,
    output logic  mem_store,
    output word_t mem_addr,
    output word_t mem_wdata,
    input  word_t mem_rdata,
    input  logic  mem_ack
);

    acc_phase_e phase_q, phase_d;
    logic       req_q, req_d;
    logic       load_q, load_d;
    logic       store_q, store_d;
    word_t      addr_q, addr_d;
    word_t      wdata_q, wdata_d;
    word_t      rdata_q, rdata_d;

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            phase_q <= ACC_ISSUE;
            req_q   <= 1'b0;
            load_q  <= 1'b0;
            store_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            phase_q <= phase_d;
            req_q   <= req_d;
            load_q  <= load_d;
            store_q <= store_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Qualifiers stay up until ack falls so memory never sees them change mid-handshake.
    always_comb begin
        phase_d = phase_q;
        req_d   = req_q;
        load_d  = load_q;
        store_d = store_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        done    = 1'b0;
        case (phase_q)
            ACC_ISSUE: begin
                if (start && !mem_ack) begin
                    req_d   = 1'b1;
                    load_d  = !is_store;
                    store_d = is_store;
                    addr_d  = addr;
                    wdata_d = wdata;
                    phase_d = ACC_WAIT_ACK;
                end
            end
            ACC_WAIT_ACK: begin
                if (mem_ack) begin
                    if (load_q) begin
                        rdata_d = mem_rdata;
                    end
                    req_d   = 1'b0;
                    phase_d = ACC_WAIT_REL;
                end
            end
            ACC_WAIT_REL: begin
                if (!mem_ack) begin
                    load_d  = 1'b0;
                    store_d = 1'b0;
                    done    = 1'b1;
                    phase_d = ACC_ISSUE;
                end
            end
            default: phase_d = ACC_ISSUE;
        endcase
    end

    assign rdata     = rdata_q;
    assign mem_req   = req_q;
    assign mem_load  = load_q;
    assign mem_store = store_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

endmodule

// File: rtl/subleq_core.sv
// SUBLEQ execution engine: fetch A,B,C; mem[B] -= mem[A]; branch to C when the result is <= 0.
// Sole master of the memory block through subleq_mem_port.
module subleq_core
    import subleq_core_pkg::*;
#(
    parameter word_t START_PC = '0,
    parameter int    CNT_BITS = 16
) (
    input  logic                clk,
    input  logic                areset,
    input  logic                run,
    output logic                mem_req,
    output logic                mem_load,
    output logic                mem_store,
    output word_t               mem_addr,
    output word_t               mem_wdata,
    input  word_t               mem_rdata,
    input  logic                mem_ack,
    output word_t               pc,
    output logic                halted,
    output logic [CNT_BITS-1:0] instr_count
);

    core_state_e         state_q, state_d;
    word_t               pc_q, pc_d;
    word_t               ra_q, ra_d;
    word_t               rb_q, rb_d;
    word_t               rc_q, rc_d;
    word_t               va_q, va_d;
    word_t               diff_q, diff_d;
    logic                halted_q, halted_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;

    logic  acc_start;
    logic  acc_store;
    word_t acc_addr;
    logic  acc_done;
    word_t acc_rdata;

    subleq_mem_port u_port (
        .clk       (clk),
        .areset    (areset),
        .start     (acc_start),
        .is_store  (acc_store),
        .addr      (acc_addr),
        .wdata     (diff_q),
        .done      (acc_done),
        .rdata     (acc_rdata),
        .mem_req   (mem_req),
        .mem_load  (mem_load),
        .mem_store (mem_store),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            state_q  <= CORE_IDLE;
            pc_q     <= START_PC;
            ra_q     <= '0;
            rb_q     <= '0;
            rc_q     <= '0;
            va_q     <= '0;
            diff_q   <= '0;
            halted_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ra_q     <= ra_d;
            rb_q     <= rb_d;
            rc_q     <= rc_d;
            va_q     <= va_d;
            diff_q   <= diff_d;
            halted_q <= halted_d;
            cnt_q    <= cnt_d;
        end
    end

    // Each access state holds start/addr steady and advances on the port's done pulse.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ra_d      = ra_q;
        rb_d      = rb_q;
        rc_d      = rc_q;
        va_d      = va_q;
        diff_d    = diff_q;
        halted_d  = halted_q;
        cnt_d     = cnt_q;
        acc_start = 1'b0;
        acc_store = 1'b0;
        acc_addr  = '0;
        case (state_q)
            CORE_IDLE: begin
                if (run && !halted_q) begin
                    state_d = CORE_FETCH_A;
                end
            end
            CORE_FETCH_A: begin
                acc_start = 1'b1;
                acc_addr  = pc_q;
                if (acc_done) begin
                    ra_d    = acc_rdata;
                    state_d = CORE_FETCH_B;
                end
            end
            CORE_FETCH_B: begin
                acc_start = 1'b1;
                acc_addr  = pc_q + word_t'(1);
                if (acc_done) begin
                    rb_d    = acc_rdata;
                    state_d = CORE_FETCH_C;
                end
            end
            CORE_FETCH_C: begin
                acc_start = 1'b1;
                acc_addr  = pc_q + word_t'(2);
                if (acc_done) begin
                    rc_d    = acc_rdata;
                    state_d = CORE_READ_A;
                end
            end
            CORE_READ_A: begin
                acc_start = 1'b1;
                acc_addr  = ra_q;
                if (acc_done) begin
                    va_d    = acc_rdata;
                    state_d = CORE_READ_B;
                end
            end
            CORE_READ_B: begin
                acc_start = 1'b1;
                acc_addr  = rb_q;
                if (acc_done) begin
                    diff_d  = acc_rdata - va_q;
                    state_d = CORE_WRITE_B;
                end
            end
            CORE_WRITE_B: begin
                acc_start = 1'b1;
                acc_store = 1'b1;
                acc_addr  = rb_q;
                if (acc_done) begin
                    state_d = CORE_RETIRE;
                end
            end
            CORE_RETIRE: begin
                if (is_leq(diff_q)) begin
                    pc_d = rc_q;
                    if (rc_q == pc_q) begin
                        halted_d = 1'b1;
                    end
                end else begin
                    pc_d = pc_q + word_t'(3);
                end
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_BITS'(1);
                end
                state_d = CORE_IDLE;
            end
            default: state_d = CORE_IDLE;
        endcase
    end

    assign pc          = pc_q;
    assign halted      = halted_q;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_subleq_core.sv
// Self-checking bench: two cores (START_PC 0 and 0xFD) each on a 4-phase memory model,
// with directed instruction steps, run/reset corner cases and a handshake monitor.
module tb_subleq_core;

    typedef struct {
        int          unit;
        logic [7:0]  expPc;
        int          expCount;
        logic        expHalted;
        logic [7:0]  memAddr;
        logic [7:0]  expMem;
        string       name;
    } stepVec_t;

    logic        clk;
    logic        areset;
    logic        run     [2];
    logic        req     [2];
    logic        load    [2];
    logic        store   [2];
    logic        ack     [2];
    logic [7:0]  addr    [2];
    logic [7:0]  wdata   [2];
    logic [7:0]  rdata   [2];
    logic [7:0]  pcO     [2];
    logic        halted  [2];
    logic [15:0] cnt     [2];

    logic [7:0]  mem     [2][256];
    logic [7:0]  img     [2][256];
    logic [1:0]  memSt   [2];

    int tests = 0;
    int failures = 0;

    logic       prevRst;
    logic       prevReq   [2];
    logic       prevAck   [2];
    logic       prevLoad  [2];
    logic       prevStore [2];
    logic [7:0] prevAddr  [2];
    logic [7:0] prevWdata [2];
    int         reqRises  [2];
    int         storeIdx  [2];
    logic [7:0] expStore  [2][10];
    int         expStoreLen [2];
    logic [7:0] loadLog1 [$];

    stepVec_t steps [5];

    subleq_core #(.START_PC(8'h00), .CNT_BITS(16)) dut0 (
        .clk(clk), .areset(areset), .run(run[0]),
        .mem_req(req[0]), .mem_load(load[0]), .mem_store(store[0]),
        .mem_addr(addr[0]), .mem_wdata(wdata[0]), .mem_rdata(rdata[0]), .mem_ack(ack[0]),
        .pc(pcO[0]), .halted(halted[0]), .instr_count(cnt[0])
    );

    subleq_core #(.START_PC(8'hFD), .CNT_BITS(16)) dut1 (
        .clk(clk), .areset(areset), .run(run[1]),
        .mem_req(req[1]), .mem_load(load[1]), .mem_store(store[1]),
        .mem_addr(addr[1]), .mem_wdata(wdata[1]), .mem_rdata(rdata[1]), .mem_ack(ack[1]),
        .pc(pcO[1]), .halted(halted[1]), .instr_count(cnt[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory: WAITREQ -> DOWORK -> WAITACK; contents reload from the image while in reset.
    always @(posedge clk or negedge areset) begin
        if (!areset) begin
            for (int u = 0; u < 2; u++) begin
                for (int k = 0; k < 256; k++) mem[u][k] <= img[u][k];
                memSt[u] <= 2'd0;
                ack[u]   <= 1'b0;
                rdata[u] <= 8'h00;
            end
        end else begin
            for (int u = 0; u < 2; u++) begin
                case (memSt[u])
                    2'd0: if (req[u]) memSt[u] <= 2'd1;
                    2'd1: begin
                        if (store[u]) mem[u][addr[u]] <= wdata[u];
                        else          rdata[u] <= mem[u][addr[u]];
                        ack[u]   <= 1'b1;
                        memSt[u] <= 2'd2;
                    end
                    2'd2: if (!req[u]) begin
                        ack[u]   <= 1'b0;
                        memSt[u] <= 2'd0;
                    end
                    default: memSt[u] <= 2'd0;
                endcase
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic waitForCount(input int u, input int target, input string name);
        for (int i = 0; i < 400 && int'(cnt[u]) != target; i++) @(negedge clk);
        checkOutput(name, 32'(cnt[u]), 32'(target));
    endtask

    task automatic waitForHalt(input string name);
        for (int i = 0; i < 1000 && !halted[0]; i++) @(negedge clk);
        checkOutput(name, 32'(halted[0]), 32'd1);
    endtask

    // Executes exactly one instruction: run is raised until the first request, then dropped.
    task automatic applyStimulus(input int u);
        int startCount;
        run[u] = 1'b1;
        for (int i = 0; i < 50 && !req[u]; i++) @(negedge clk);
        checkOutput("instr start", 32'(req[u]), 32'd1);
        run[u] = 1'b0;
        startCount = int'(cnt[u]);
        waitForCount(u, startCount + 1, "retire");
        repeat (3) @(negedge clk);
    endtask

    task automatic monitorStep();
        for (int u = 0; u < 2; u++) begin
            if (req[u] && !prevReq[u]) begin
                reqRises[u]++;
                checkOutput("req rise with ack low", 32'(prevAck[u]), 32'd0);
                if (u == 1 && load[u]) loadLog1.push_back(addr[u]);
            end
            if (req[u]) checkOutput("one qualifier with req", 32'({load[u], store[u]} == 2'b01 || {load[u], store[u]} == 2'b10), 32'd1);
            if (store[u] && !prevStore[u]) begin
                if (storeIdx[u] < expStoreLen[u]) checkOutput("store address", 32'(addr[u]), 32'(expStore[u][storeIdx[u]]));
                else checkOutput("store count", 32'(storeIdx[u] + 1), 32'(expStoreLen[u]));
                storeIdx[u]++;
            end
            if ((req[u] || ack[u]) && (prevReq[u] || prevAck[u])) begin
                checkOutput("addr stable", 32'(addr[u]), 32'(prevAddr[u]));
                checkOutput("load stable", 32'(load[u]), 32'(prevLoad[u]));
                checkOutput("store stable", 32'(store[u]), 32'(prevStore[u]));
                checkOutput("wdata stable", 32'(wdata[u]), 32'(prevWdata[u]));
            end
        end
    endtask

    initial begin
        int r;
        areset = 1'b0;
        run[0] = 1'b0;
        run[1] = 1'b0;
        prevRst = 1'b0;
        for (int u = 0; u < 2; u++) begin
            prevReq[u] = 1'b0; prevAck[u] = 1'b0; prevLoad[u] = 1'b0; prevStore[u] = 1'b0;
            prevAddr[u] = 8'h00; prevWdata[u] = 8'h00; reqRises[u] = 0; storeIdx[u] = 0;
            for (int k = 0; k < 256; k++) img[u][k] = 8'h00;
        end
        // Unit 0: three-instruction program ending in a self-jump.
        img[0][0] = 8'd9;  img[0][1] = 8'd10; img[0][2] = 8'd3;
        img[0][3] = 8'd10; img[0][4] = 8'd10; img[0][5] = 8'd6;
        img[0][6] = 8'd11; img[0][7] = 8'd11; img[0][8] = 8'd6;
        img[0][9] = 8'd5;  img[0][10] = 8'd7; img[0][11] = 8'd0;
        // Unit 1: wrapping instruction at 0xFD, then a negative-result instruction at 0.
        img[1][8'hFD] = 8'h20; img[1][8'hFE] = 8'h21; img[1][8'hFF] = 8'h30;
        img[1][8'h20] = 8'd3;  img[1][8'h21] = 8'd10;
        img[1][0] = 8'd9; img[1][1] = 8'd10; img[1][2] = 8'd3;
        img[1][9] = 8'd5; img[1][10] = 8'd3;

        expStoreLen[0] = 10;
        expStore[0] = '{8'd10, 8'd10, 8'd11, 8'd10, 8'd10, 8'd11, 8'd10, 8'd10, 8'd10, 8'd11};
        expStoreLen[1] = 2;
        expStore[1] = '{8'h21, 8'd10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

        steps[0] = '{0, 8'h03, 1, 1'b0, 8'd10,  8'h02, "positive step"};
        steps[1] = '{0, 8'h06, 2, 1'b0, 8'd10,  8'h00, "zero branch"};
        steps[2] = '{0, 8'h06, 3, 1'b1, 8'd11,  8'h00, "self-jump halt"};
        steps[3] = '{1, 8'h00, 1, 1'b0, 8'h21,  8'h07, "wrap"};
        steps[4] = '{1, 8'h03, 2, 1'b0, 8'd10,  8'hFE, "negative result"};

        fork
            forever begin
                @(negedge clk);
                if (areset && prevRst) monitorStep();
                for (int u = 0; u < 2; u++) begin
                    prevReq[u] = req[u]; prevAck[u] = ack[u]; prevLoad[u] = load[u];
                    prevStore[u] = store[u]; prevAddr[u] = addr[u]; prevWdata[u] = wdata[u];
                end
                prevRst = areset;
            end
        join_none

        repeat (3) @(negedge clk);
        checkOutput("reset pc0", 32'(pcO[0]), 32'h00);
        checkOutput("reset pc1", 32'(pcO[1]), 32'hFD);
        checkOutput("reset halted", 32'(halted[0]), 32'd0);
        checkOutput("reset count", 32'(cnt[0]), 32'd0);
        checkOutput("reset req", 32'(req[0]), 32'd0);
        checkOutput("reset load", 32'(load[0]), 32'd0);
        checkOutput("reset store", 32'(store[0]), 32'd0);
        checkOutput("reset addr", 32'(addr[0]), 32'd0);
        checkOutput("reset wdata", 32'(wdata[0]), 32'd0);
        areset = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            applyStimulus(steps[i].unit);
            $display("[TB] step %0d: %s", i, steps[i].name);
            checkOutput({steps[i].name, " pc"}, 32'(pcO[steps[i].unit]), 32'(steps[i].expPc));
            checkOutput({steps[i].name, " count"}, 32'(cnt[steps[i].unit]), 32'(steps[i].expCount));
            checkOutput({steps[i].name, " halted"}, 32'(halted[steps[i].unit]), 32'(steps[i].expHalted));
            checkOutput({steps[i].name, " mem"}, 32'(mem[steps[i].unit][steps[i].memAddr]), 32'(steps[i].expMem));
            if (i == 3) begin
                checkOutput("wrap load count", 32'(loadLog1.size() >= 5), 32'd1);
                if (loadLog1.size() >= 5) begin
                    checkOutput("wrap fetch A", 32'(loadLog1[0]), 32'hFD);
                    checkOutput("wrap fetch B", 32'(loadLog1[1]), 32'hFE);
                    checkOutput("wrap fetch C", 32'(loadLog1[2]), 32'hFF);
                    checkOutput("wrap read A", 32'(loadLog1[3]), 32'h20);
                    checkOutput("wrap read B", 32'(loadLog1[4]), 32'h21);
                end
            end
        end

        // Halted core must ignore run.
        r = reqRises[0];
        run[0] = 1'b1;
        repeat (40) @(negedge clk);
        checkOutput("no req after halt", 32'(reqRises[0]), 32'(r));
        checkOutput("halt sticky", 32'(halted[0]), 32'd1);
        checkOutput("halt pc", 32'(pcO[0]), 32'h06);
        run[0] = 1'b0;

        // run dropped during READ_A of the first instruction.
        areset = 1'b0;
        repeat (3) @(negedge clk);
        areset = 1'b1;
        run[0] = 1'b1;
        for (int i = 0; i < 200 && !(req[0] && load[0] && addr[0] == 8'd9); i++) @(negedge clk);
        checkOutput("reached READ_A", 32'(addr[0]), 32'd9);
        run[0] = 1'b0;
        waitForCount(0, 1, "run-drop retire");
        r = reqRises[0];
        repeat (30) @(negedge clk);
        checkOutput("run-drop idle count", 32'(cnt[0]), 32'd1);
        checkOutput("run-drop idle pc", 32'(pcO[0]), 32'h03);
        checkOutput("run-drop no req", 32'(reqRises[0]), 32'(r));
        run[0] = 1'b1;
        waitForHalt("resume halt");
        checkOutput("resume pc", 32'(pcO[0]), 32'h06);
        checkOutput("resume count", 32'(cnt[0]), 32'd3);
        checkOutput("resume mem10", 32'(mem[0][10]), 32'h00);
        run[0] = 1'b0;

        // Reset asserted while the first store waits for ack.
        areset = 1'b0;
        repeat (3) @(negedge clk);
        areset = 1'b1;
        run[0] = 1'b1;
        for (int i = 0; i < 400 && !(req[0] && store[0] && !ack[0]); i++) @(negedge clk);
        checkOutput("reached WRITE_B", 32'(store[0] && req[0]), 32'd1);
        #2 areset = 1'b0;
        #1;
        checkOutput("async req drop", 32'(req[0]), 32'd0);
        checkOutput("async store drop", 32'(store[0]), 32'd0);
        checkOutput("reset mid pc", 32'(pcO[0]), 32'h00);
        checkOutput("reset mid count", 32'(cnt[0]), 32'd0);
        checkOutput("reset mid halted", 32'(halted[0]), 32'd0);
        repeat (3) @(negedge clk);
        areset = 1'b1;
        waitForHalt("rerun halt");
        checkOutput("rerun pc", 32'(pcO[0]), 32'h06);
        checkOutput("rerun count", 32'(cnt[0]), 32'd3);
        checkOutput("rerun mem10", 32'(mem[0][10]), 32'h00);
        checkOutput("rerun mem11", 32'(mem[0][11]), 32'h00);
        run[0] = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("store total u0", 32'(storeIdx[0]), 32'(expStoreLen[0]));
        checkOutput("store total u1", 32'(storeIdx[1]), 32'(expStoreLen[1]));

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/subleq_core.md
Name: subleq_core

Overview:
- SUBLEQ execution engine; sits directly upstream of the memory block and is its only master.
- Fetches the operand triple A, B, C at pc, pc+1, pc+2. Computes mem[B] := mem[B] - mem[A]. Branches to C when the result is <= 0 (signed), else advances to pc+3.
- Every memory access uses the 4-phase req/ack handshake with load/store qualifiers.

Parameters:
- START_PC, 0, pc value loaded on reset (WORD_SIZE bits).
- CNT_BITS, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock
- areset  in  1  asynchronous reset, active-low
- run  in  1  high = execute; sampled only at instruction boundaries
- mem_req  out  1  handshake request to memory
- mem_load  out  1  read qualifier; held with req
- mem_store  out  1  write qualifier; held with req
- mem_addr  out  WORD_SIZE  access address
- mem_wdata  out  WORD_SIZE  store data (memory `in`)
- mem_rdata  in  WORD_SIZE  load data (memory `out`); valid while load && ack
- mem_ack  in  1  handshake acknowledge
- pc  out  WORD_SIZE  address of the current/next instruction
- halted  out  1  sticky halt flag
- instr_count  out  CNT_BITS  retired instructions, saturating

Behaviour:
- Reset (areset low, async), all outputs forced immediately:
  - mem_req, mem_load, mem_store = 0; mem_addr, mem_wdata = 0.
  - pc = START_PC; halted = 0; instr_count = 0; state = IDLE.
- Main FSM:
  - IDLE: if run && !halted -> FETCH_A.
  - FETCH_A: load pc -> ra.
  - FETCH_B: load pc+1 -> rb.
  - FETCH_C: load pc+2 -> rc.
  - READ_A: load ra -> va.
  - READ_B: load rb -> vb.
  - WRITE_B: store diff at rb.
  - RETIRE: update pc/halted/instr_count -> IDLE.
- Access sub-phases, per access state:
  - ISSUE: wait !mem_ack; then register req=1 with addr/load/store/wdata.
  - WAIT_ACK: on mem_ack=1, capture mem_rdata (loads) and drop req.
  - WAIT_REL: on mem_ack=0, advance the main FSM.
- Handshake rules:
  - addr, load, store and wdata are stable from req rise until ack falls.
  - load and store are never both 1.
  - req never rises while ack=1.
  - All outputs are registered.
- Arithmetic:
  - diff = vb - va modulo 2^WORD_SIZE.
  - leq = (diff == 0) || diff[WORD_SIZE-1].
  - pc+1, pc+2 and pc+3 wrap modulo 2^WORD_SIZE.
- RETIRE:
  - If leq: pc <= rc, else pc <= pc+3.
  - instr_count increments and saturates at all-ones.
  - If leq && rc == pc (self-jump): halted <= 1. The store has already completed and pc stays at rc.
- Halted: the core stays in IDLE, issues no requests, and only reset clears it.
- run low mid-instruction: the instruction completes; the core stops in IDLE.
- Reset mid-access: req drops asynchronously. The system top resets memory on the same event (inverted polarity), so no stale handshake survives.
- Latency: each access is at least 4 clk against the memory FSM (WAITREQ -> DOWORK -> WAITACK -> WAITREQ); one instruction takes at least 6 accesses + 1 cycle.
- A == B is legal: diff = 0 and the branch is taken.

Decomposition:
- defines.vh holds the shared constants:
  - WORD_SIZE and the existing IO_* handshake states.
  - New CORE_STATE_BITS and CORE_* main-FSM encodings.
  - New ACC_* sub-phase encodings.
- One sub-module, subleq_mem_port, owns the ISSUE/WAIT_ACK/WAIT_REL handshake and the rdata capture.
  - Inputs from the core: start, is_store, addr, wdata.
  - Outputs to the core: done pulse, rdata.

Test Plan (WORD_SIZE=8, real memory model, START_PC=0):
- Program 0:{9,10,3} 3:{10,10,6} 6:{11,11,6}; mem[9]=5, mem[10]=7, mem[11]=0; run=1.
  - -> mem[10]: 2 after instr 1, then 0 after instr 2.
  - -> halted=1, pc=6, instr_count=3; no req after halt.
- Negative result: mem[9]=5, mem[10]=3, instr 0:{9,10,3}.
  - -> mem[10]=0xFE, branch taken, pc=3.
- Wrap: START_PC=0xFD, positive result.
  - -> operands fetched from 0xFD, 0xFE, 0xFF; pc becomes 0x00.
- Handshake monitor over a full run:
  - req never rises while ack=1.
  - addr, load and wdata constant while req||ack.
  - store asserted exactly once per instruction, at address B.
- run dropped during READ_A.
  - -> instruction completes, core idles in IDLE; run=1 resumes at the next pc.
- areset low during WAIT_ACK of WRITE_B.
  - -> mem_req=0 immediately; after release pc=0, instr_count=0, halted=0, and the program re-executes correctly.
